// File: rtl/cpu_muldiv_pkg.sv
// Shared opcode encodings, FSM state type and opcode-decode helpers for the
// MUL/DIV scheduler.
package cpu_muldiv_pkg;

  localparam int MD_OP_WIDTH = 3;

  localparam logic [2:0] MD_OP_MULW   = 3'd0;
  localparam logic [2:0] MD_OP_MULHW  = 3'd1;
  localparam logic [2:0] MD_OP_MULHWU = 3'd2;
  localparam logic [2:0] MD_OP_DIVW   = 3'd4;
  localparam logic [2:0] MD_OP_DIVUW  = 3'd5;
  localparam logic [2:0] MD_OP_MODW   = 3'd6;
  localparam logic [2:0] MD_OP_MODUW  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } md_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_mod(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_mul_high(input logic [2:0] op);
    return (op == MD_OP_MULHW) || (op == MD_OP_MULHWU);
  endfunction

  // Any opcode that is not a known unsigned form decodes as signed, so the
  // unused encoding 3 behaves exactly like MULW.
  function automatic logic op_signed(input logic [2:0] op);
    if (op[2]) begin
      return ~op[0];
    end
    return op != MD_OP_MULHWU;
  endfunction

endpackage

// File: rtl/muldiv_rr_arb.sv
// Two-way arbiter for the shared MUL/DIV units; round-robin on ties unless
// FIXED_PRIO pins the tie to pipe 0.
module muldiv_rr_arb #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    unique case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
      default: gnt_idx_o = 1'b0;
    endcase
  end

  assign last_d = accept_i ? gnt_idx_o : last_q;

  // last_q resets to pipe 1 so that pipe 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/muldiv_sched.sv
// Shares one multiplier and one divider between the two EX issue pipes:
// arbitrates requests, sequences the unit handshake and returns results.
module muldiv_sched
  import cpu_muldiv_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int MD_OP_W    = MD_OP_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid_i,
  input  logic [1:0][MD_OP_W-1:0] req_op_i,
  input  logic [1:0][31:0]        req_src1_i,
  input  logic [1:0][31:0]        req_src2_i,
  input  logic [1:0]              flush_i,
  output logic [1:0]              done_o,
  output logic [31:0]             result_o,
  output logic                    busy_o,
  output logic                    owner_o,
  output logic                    mul_start_o,
  output logic                    mul_signed_o,
  output logic [31:0]             mul_data1_o,
  output logic [31:0]             mul_data2_o,
  input  logic                    mul_done_i,
  input  logic [63:0]             mul_result_i,
  output logic                    div_start_o,
  output logic                    div_signed_o,
  output logic [31:0]             div_dividend_o,
  output logic [31:0]             div_divisor_o,
  input  logic                    div_done_i,
  input  logic [31:0]             div_quotient_i,
  input  logic [31:0]             div_remainder_i
);

  md_state_e          state_q, state_d;
  logic               owner_q, owner_d;
  logic               killed_q, killed_d;
  logic [MD_OP_W-1:0] op_q, op_d;
  logic [31:0]        src1_q, src1_d;
  logic [31:0]        src2_q, src2_d;
  logic [31:0]        result_q, result_d;

  logic [1:0]         eligible;
  logic               gnt_valid;
  logic               gnt_idx;
  logic               grant_accept;
  logic [MD_OP_W-1:0] gnt_op;
  logic [31:0]        gnt_src1;
  logic [31:0]        gnt_src2;
  logic               flush_own;
  logic               kill_now;
  logic               op_is_div;
  logic               unit_done;
  logic [31:0]        unit_result;
  logic               busy;

  assign eligible     = req_valid_i & ~flush_i;
  assign grant_accept = (state_q == ST_IDLE) && gnt_valid;

  muldiv_rr_arb #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (eligible),
    .accept_i    (grant_accept),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign gnt_op    = req_op_i[gnt_idx];
  assign gnt_src1  = req_src1_i[gnt_idx];
  assign gnt_src2  = req_src2_i[gnt_idx];
  assign flush_own = flush_i[owner_q];
  assign kill_now  = killed_q | flush_own;
  assign op_is_div = is_div(op_q[2:0]);
  // Only the unit that was started can complete this request.
  assign unit_done = op_is_div ? div_done_i : mul_done_i;

  always_comb begin
    unit_result = mul_result_i[31:0];
    if (op_is_div) begin
      unit_result = is_mod(op_q[2:0]) ? div_remainder_i : div_quotient_i;
    end else if (is_mul_high(op_q[2:0])) begin
      unit_result = mul_result_i[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      killed_q <= 1'b0;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    killed_d = killed_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d  = gnt_idx;
          op_d     = gnt_op;
          src1_d   = gnt_src1;
          src2_d   = gnt_src2;
          killed_d = 1'b0;
          // Divide-by-zero never reaches the divider: answer is known now.
          if (is_div(gnt_op[2:0]) && (gnt_src2 == 32'd0)) begin
            result_d = is_mod(gnt_op[2:0]) ? gnt_src1 : 32'd0;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        killed_d = kill_now;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (unit_done) begin
          result_d = unit_result;
          killed_d = 1'b0;
          state_d  = kill_now ? ST_IDLE : ST_RESP;
        end else begin
          killed_d = kill_now;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    busy_o         = busy;
    owner_o        = owner_q;
    mul_start_o    = (state_q == ST_ISSUE) && !op_is_div;
    div_start_o    = (state_q == ST_ISSUE) && op_is_div;
    mul_signed_o   = busy && !op_is_div && op_signed(op_q[2:0]);
    div_signed_o   = busy && op_is_div && op_signed(op_q[2:0]);
    mul_data1_o    = src1_q;
    mul_data2_o    = src2_q;
    div_dividend_o = src1_q;
    div_divisor_o  = src2_q;
    result_o       = result_q;
    done_o         = 2'b00;
    if ((state_q == ST_RESP) && !flush_own) begin
      done_o[owner_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with behavioural latency models of the
// multiplier and divider attached to the unit handshake.
module tb_muldiv_sched;
  import cpu_muldiv_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0][2:0]  req_op = '0;
  logic [1:0][31:0] src1 = '0;
  logic [1:0][31:0] src2 = '0;
  logic [1:0]       flush = '0;
  logic [1:0]       done_o;
  logic [31:0]      result_o;
  logic             busy_o, owner_o;
  logic             mul_start_o, mul_signed_o, mul_done;
  logic [31:0]      mul_data1_o, mul_data2_o;
  logic [63:0]      prod_r;
  logic             div_start_o, div_signed_o, div_done;
  logic [31:0]      div_dividend_o, div_divisor_o, quot_r, rem_r;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mul_lat = 3;
  int div_lat = 4;
  int mcnt = 0;
  int dcnt = 0;

  muldiv_sched #(.FIXED_PRIO(0), .MD_OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_op_i(req_op),
    .req_src1_i(src1), .req_src2_i(src2), .flush_i(flush),
    .done_o(done_o), .result_o(result_o), .busy_o(busy_o), .owner_o(owner_o),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_data1_o(mul_data1_o), .mul_data2_o(mul_data2_o),
    .mul_done_i(mul_done), .mul_result_i(prod_r),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_done_i(div_done), .div_quotient_i(quot_r), .div_remainder_i(rem_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit models: done is high exactly lat cycles after the start cycle.
  always @(posedge clk) begin
    if (!rst) begin
      mcnt <= 0;
      prod_r <= '0;
    end else if (mul_start_o) begin
      mcnt <= mul_lat;
      prod_r <= (mul_signed_o ? {{32{mul_data1_o[31]}}, mul_data1_o} : {32'b0, mul_data1_o}) *
                (mul_signed_o ? {{32{mul_data2_o[31]}}, mul_data2_o} : {32'b0, mul_data2_o});
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign mul_done = (mcnt == 1);

  always @(posedge clk) begin
    if (!rst) begin
      dcnt <= 0;
      quot_r <= '0;
      rem_r <= '0;
    end else if (div_start_o) begin
      dcnt <= div_lat;
      if (div_signed_o) begin
        quot_r <= $signed(div_dividend_o) / $signed(div_divisor_o);
        rem_r  <= $signed(div_dividend_o) % $signed(div_divisor_o);
      end else begin
        quot_r <= div_dividend_o / div_divisor_o;
        rem_r  <= div_dividend_o % div_divisor_o;
      end
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = (dcnt == 1);

  int mul_starts = 0;
  int div_starts = 0;
  int mul_start_cyc = -1;
  int done_count = 0;
  logic mul_sign_seen = 1'b0;
  logic [31:0] mul_d1_seen = '0;
  logic [31:0] mul_d2_seen = '0;

  always @(negedge clk) begin
    if (mul_start_o) begin
      mul_starts++;
      mul_start_cyc = cyc;
      mul_sign_seen = mul_signed_o;
      mul_d1_seen = mul_data1_o;
      mul_d2_seen = mul_data2_o;
    end
    if (div_start_o) div_starts++;
    if (done_o != 2'b00) begin
      done_count++;
      $display("txn cyc=%0d done=%b result=%h", cyc, done_o, result_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[p] = 1'b1;
    req_op[p] = op;
    src1[p] = a;
    src2[p] = b;
  endtask

  task automatic wait_done(input int budget, output bit got, output int dc,
                           output logic [1:0] dv, output logic [31:0] dr);
    got = 0; dc = -1; dv = '0; dr = '0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done_o != 2'b00) begin
        got = 1; dc = cyc; dv = done_o; dr = result_o;
      end
    end
  endtask

  task automatic run_one(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int t0, output bit got, output int dc,
                         output logic [1:0] dv, output logic [31:0] dr);
    tick();
    issue(p, op, a, b);
    t0 = cyc;
    wait_done(30, got, dc, dv, dr);
    req_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    flush = '0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    issue(0, MD_OP_DIVW, 32'd9, 32'd3);
    repeat (2) tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", done_o); end
    total++; if ({mul_start_o, div_start_o} !== 2'b00) begin bad++; $display("FAIL rst_start got=%b exp=00", {mul_start_o, div_start_o}); end
    total++; if ({mul_signed_o, div_signed_o, owner_o} !== 3'b000) begin bad++; $display("FAIL rst_ctl got=%b exp=000", {mul_signed_o, div_signed_o, owner_o}); end
    total++; if ({mul_data1_o, div_divisor_o, result_o} !== 96'd0) begin bad++; $display("FAIL rst_data got=%h exp=0", {mul_data1_o, div_divisor_o, result_o}); end
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_mul();
    int t0, dc; bit got; logic [1:0] dv; logic [31:0] dr;
    mul_lat = 3;
    do_reset();
    run_one(0, MD_OP_MULW, 32'd7, 32'hFFFF_FFFD, t0, got, dc, dv, dr);
    total++; if (!got) begin bad++; $display("FAIL mulw_timeout got=none exp=done"); end
    total++; if (mul_start_cyc !== t0 + 1) begin bad++; $display("FAIL mulw_start_cyc got=%0d exp=%0d", mul_start_cyc, t0 + 1); end
    total++; if (mul_sign_seen !== 1'b1) begin bad++; $display("FAIL mulw_signed got=%b exp=1", mul_sign_seen); end
    total++; if ({mul_d1_seen, mul_d2_seen} !== {32'd7, 32'hFFFF_FFFD}) begin bad++; $display("FAIL mulw_data got=%h exp=%h", {mul_d1_seen, mul_d2_seen}, {32'd7, 32'hFFFF_FFFD}); end
    total++; if (dc !== t0 + 5) begin bad++; $display("FAIL mulw_latency got=%0d exp=%0d", dc, t0 + 5); end
    total++; if (dv !== 2'b01) begin bad++; $display("FAIL mulw_done got=%b exp=01", dv); end
    total++; if (dr !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mulw_result got=%h exp=ffffffeb", dr); end
    run_one(0, MD_OP_MULHW, 32'd7, 32'hFFFF_FFFD, t0, got, dc, dv, dr);
    total++; if (dr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhw_result got=%h exp=ffffffff", dr); end
    run_one(1, MD_OP_MULHWU, 32'd7, 32'hFFFF_FFFD, t0, got, dc, dv, dr);
    total++; if (dr !== 32'd6) begin bad++; $display("FAIL mulhwu_result got=%h exp=00000006", dr); end
    total++; if (mul_sign_seen !== 1'b0) begin bad++; $display("FAIL mulhwu_signed got=%b exp=0", mul_sign_seen); end
    total++; if (dv !== 2'b10) begin bad++; $display("FAIL mulhwu_done got=%b exp=10", dv); end
  endtask

  task automatic test_rr();
    int t0, dc; bit got; logic [1:0] dv; logic [31:0] dr;
    div_lat = 4;
    mul_lat = 3;
    do_reset();
    tick();
    issue(0, MD_OP_DIVW, 32'd100, 32'd7);
    issue(1, MD_OP_MODUW, 32'd100, 32'd7);
    t0 = cyc;
    wait_done(30, got, dc, dv, dr);
    total++; if ({dv, dr} !== {2'b01, 32'd14}) begin bad++; $display("FAIL rr_first got=%b/%h exp=01/0000000e", dv, dr); end
    total++; if (dc !== t0 + 6) begin bad++; $display("FAIL rr_first_cyc got=%0d exp=%0d", dc, t0 + 6); end
    // Pipe 0 moves straight on to its next instruction: a fresh tie.
    issue(0, MD_OP_MULW, 32'd6, 32'd7);
    wait_done(30, got, dc, dv, dr);
    total++; if ({dv, dr} !== {2'b10, 32'd2}) begin bad++; $display("FAIL rr_second got=%b/%h exp=10/00000002", dv, dr); end
    total++; if (dc !== t0 + 13) begin bad++; $display("FAIL rr_second_cyc got=%0d exp=%0d", dc, t0 + 13); end
    req_valid[1] = 1'b0;
    wait_done(30, got, dc, dv, dr);
    total++; if ({dv, dr} !== {2'b01, 32'd42}) begin bad++; $display("FAIL rr_third got=%b/%h exp=01/0000002a", dv, dr); end
    req_valid[0] = 1'b0;
  endtask

  task automatic test_divzero();
    int t0, dc, ds0; bit got; logic [1:0] dv; logic [31:0] dr;
    ds0 = div_starts;
    run_one(0, MD_OP_DIVW, 32'd55, 32'd0, t0, got, dc, dv, dr);
    total++; if (dc !== t0 + 1) begin bad++; $display("FAIL dz_div_cyc got=%0d exp=%0d", dc, t0 + 1); end
    total++; if ({dv, dr} !== {2'b01, 32'd0}) begin bad++; $display("FAIL dz_div_result got=%b/%h exp=01/00000000", dv, dr); end
    run_one(1, MD_OP_MODW, 32'd55, 32'd0, t0, got, dc, dv, dr);
    total++; if ({dv, dr} !== {2'b10, 32'd55}) begin bad++; $display("FAIL dz_mod_result got=%b/%h exp=10/00000037", dv, dr); end
    total++; if (div_starts !== ds0) begin bad++; $display("FAIL dz_no_start got=%0d exp=%0d", div_starts, ds0); end
  endtask

  task automatic test_flush();
    int t0, dc; bit got; logic [1:0] dv; logic [31:0] dr;
    bit busy_drop, early_done;
    div_lat = 8;
    mul_lat = 3;
    busy_drop = 0;
    early_done = 0;
    tick();
    issue(1, MD_OP_DIVW, 32'd100, 32'd7);
    t0 = cyc;
    tick();
    total++; if ({div_start_o, owner_o} !== 2'b11) begin bad++; $display("FAIL fl_start got=%b exp=11", {div_start_o, owner_o}); end
    tick();
    issue(0, MD_OP_MULW, 32'd2, 32'd3);
    tick();
    flush[1] = 1'b1;
    req_valid[1] = 1'b0;
    tick();
    flush[1] = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      tick();
      if (!busy_o) busy_drop = 1;
      if (done_o != 2'b00) early_done = 1;
    end
    total++; if (busy_drop !== 1'b0) begin bad++; $display("FAIL fl_busy_hold got=dropped exp=held"); end
    total++; if (early_done !== 1'b0) begin bad++; $display("FAIL fl_no_done got=done exp=none"); end
    tick();
    total++; if ({busy_o, done_o} !== 3'b000) begin bad++; $display("FAIL fl_idle got=%b exp=000", {busy_o, done_o}); end
    tick();
    total++; if (mul_start_o !== 1'b1) begin bad++; $display("FAIL fl_queued_start got=%b exp=1", mul_start_o); end
    wait_done(30, got, dc, dv, dr);
    req_valid[0] = 1'b0;
    total++; if ({dv, dr} !== {2'b01, 32'd6}) begin bad++; $display("FAIL fl_queued_result got=%b/%h exp=01/00000006", dv, dr); end
    total++; if (dc !== t0 + 15) begin bad++; $display("FAIL fl_queued_cyc got=%0d exp=%0d", dc, t0 + 15); end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, ms0, dn0; bit got; logic [1:0] dv; logic [31:0] dr1, dr2;
    mul_lat = 3;
    tick();
    ms0 = mul_starts;
    dn0 = done_count;
    issue(0, MD_OP_MULW, 32'd3, 32'd4);
    wait_done(30, got, dc1, dv, dr1);
    tick();
    // Request stayed high through RESP; this IDLE cycle carries the next one.
    issue(0, MD_OP_MULW, 32'd5, 32'd5);
    wait_done(30, got, dc2, dv, dr2);
    req_valid[0] = 1'b0;
    repeat (6) tick();
    total++; if (dr1 !== 32'd12) begin bad++; $display("FAIL b2b_first got=%h exp=0000000c", dr1); end
    total++; if (dr2 !== 32'd25) begin bad++; $display("FAIL b2b_second got=%h exp=00000019", dr2); end
    total++; if (dc2 !== dc1 + 6) begin bad++; $display("FAIL b2b_cyc got=%0d exp=%0d", dc2, dc1 + 6); end
    total++; if (mul_starts - ms0 !== 2) begin bad++; $display("FAIL b2b_starts got=%0d exp=2", mul_starts - ms0); end
    total++; if (done_count - dn0 !== 2) begin bad++; $display("FAIL b2b_dones got=%0d exp=2", done_count - dn0); end
  endtask

  task automatic test_reset_mid();
    int t0, dc, dn0; bit got; logic [1:0] dv; logic [31:0] dr;
    div_lat = 6;
    tick();
    dn0 = done_count;
    issue(0, MD_OP_DIVW, 32'd100, 32'd7);
    repeat (3) tick();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy_o); end
    total++; if ({mul_start_o, div_start_o, done_o} !== 4'b0000) begin bad++; $display("FAIL rm_outputs got=%b exp=0000", {mul_start_o, div_start_o, done_o}); end
    rst = 1'b1;
    run_one(0, MD_OP_MODW, 32'd100, 32'd7, t0, got, dc, dv, dr);
    repeat (8) tick();
    total++; if ({dv, dr} !== {2'b01, 32'd2}) begin bad++; $display("FAIL rm_fresh got=%b/%h exp=01/00000002", dv, dr); end
    total++; if (dc !== t0 + 8) begin bad++; $display("FAIL rm_fresh_cyc got=%0d exp=%0d", dc, t0 + 8); end
    total++; if (done_count - dn0 !== 1) begin bad++; $display("FAIL rm_done_count got=%0d exp=1", done_count - dn0); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_rr();
    test_divzero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Scheduler that shares one multi-cycle multiplier (mul_alu) and one iterative divider (div_alu) between the two ALU issue pipes of the dual-issue EX stage.
- Accepts MUL/DIV requests from pipe 0 and pipe 1 and arbitrates them round-robin.
- Sequences the start/done handshake of the selected unit and returns the result to the owning pipe with a one-cycle done pulse.
- Handles flush of the owning pipe, and short-circuits divide-by-zero without starting the divider.

Parameters:
- FIXED_PRIO, 0, 1 = pipe 0 always wins a tie; 0 = round-robin.
- MD_OP_W, 3, width of the muldiv opcode (encoding in package).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- req_valid_i  in  2  per-pipe request; held with stable operands until done_o of that pipe
- req_op_i  in  2x3  per-pipe op: MULW, MULHW, MULHWU, DIVW, DIVUW, MODW, MODUW
- req_src1_i  in  2x32  operand 1 per pipe
- req_src2_i  in  2x32  operand 2 per pipe
- flush_i  in  2  per-pipe flush
- done_o  out  2  one-cycle result pulse per pipe
- result_o  out  32  result, valid when any done_o bit is 1
- busy_o  out  1  scheduler not IDLE
- owner_o  out  1  pipe currently being served
- mul_start_o  out  1  one-cycle start pulse to mul_alu
- mul_signed_o  out  1  signed multiply
- mul_data1_o  out  32  multiplicand
- mul_data2_o  out  32  multiplier
- mul_done_i  in  1  mul_alu done
- mul_result_i  in  64  product
- div_start_o  out  1  one-cycle start pulse to div_alu
- div_signed_o  out  1  signed divide
- div_dividend_o  out  32  dividend
- div_divisor_o  out  32  divisor
- div_done_i  in  1  div_alu done
- div_quotient_i  in  32  quotient
- div_remainder_i  in  32  remainder

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE; all outputs are 0.
  - last_grant=1, so pipe 0 wins the first tie.
  - killed=0.
  - Operand and op registers go to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T:
  - Eligible pipe p: req_valid_i[p] & ~flush_i[p].
  - If both pipes are eligible: grant ~last_grant (round-robin), or pipe 0 when FIXED_PRIO=1.
  - On grant: latch owner, op, src1, src2; set last_grant=owner; go to ISSUE.
  - Exception: DIV/MOD op with src2==0 goes straight to RESP with result DIV*=0 or MOD*=src1. No div_start is issued.
- ISSUE, cycle T+1:
  - Pulse mul_start_o or div_start_o for exactly one cycle.
  - Data outputs drive the latched operands and stay stable until RESP.
  - Go to WAIT.
- WAIT:
  - On the selected unit's done (mul_done_i or div_done_i), latch the result per op. Then go to RESP if killed=0, else go to IDLE and clear killed.
  - Result selection: MULW = prod[31:0]; MULHW and MULHWU = prod[63:32]; DIVW and DIVUW = quotient; MODW and MODUW = remainder.
  - Done from the non-selected unit is ignored.
- RESP:
  - done_o[owner]=1 for one cycle; result_o = latched result; go to IDLE.
  - req_valid_i sampled during RESP is ignored. The pipe advances on done_o, and a new request is evaluated in the following IDLE cycle. This prevents re-executing the same instruction.
- Latency: with unit latency L (done asserted L cycles after start), done_o is at T+2+L. Divide-by-zero: done_o at T+1.
- Signedness: mul_signed_o = op in {MULW, MULHW}; div_signed_o = op in {DIVW, MODW}.
- Flush:
  - flush_i[owner] in ISSUE or WAIT sets killed. The start pulse is still issued, the unit runs to done (units are not abortable), and no done_o is produced.
  - flush_i[owner] in RESP suppresses done_o and returns to IDLE.
  - Flush of the non-owner pipe has no effect on the scheduler state.
- Pending request: a pipe that is not granted simply keeps req_valid_i high; there is no queue. busy_o=1 in every state except IDLE.
- Reset mid-operation: the scheduler returns to IDLE immediately. mul_alu and div_alu share the same rst and reset in the same cycle, so no stale done is seen.
- Unknown op: treated as MULW. Not expected from decode.

Decomposition:
- Package cpu_muldiv_pkg holds:
  - the MD_OP_* encodings (MULW=0, MULHW=1, MULHWU=2, DIVW=4, DIVUW=5, MODW=6, MODUW=7);
  - the state enum;
  - the is_div(op) = op[2] convention.
- One natural sub-module: muldiv_rr_arb (2-way round-robin arbiter with FIXED_PRIO). The FSM and result mux stay inline.

Test Plan:
- Single MULW on pipe 0, src1=7, src2=-3, mul L=3: mul_start_o at T+1 with mul_signed_o=1; done_o=2'b01 at T+5; result_o=32'hFFFFFFEB.
- Both pipes request in the same cycle after reset, pipe 0 DIVW 100/7 and pipe 1 MODUW 100/7: pipe 0 is served first (result 14), then pipe 1 (result 2). A following simultaneous pair is served pipe 1 first.
- DIVW with src2=0, src1=55: no div_start_o; done_o at T+1 with result 0. MODW 55/0: result 55.
- Flush of pipe 1 two cycles after its div_start_o: no done_o[1]; busy_o stays 1 until div_done_i, then IDLE; a queued pipe 0 request is granted the next cycle.
- req_valid_i[0] held high through RESP: exactly one done_o pulse and one mul_start_o per instruction.
- rst=0 during WAIT: next cycle busy_o=0 and all start/done outputs are 0; a fresh request after reset completes normally.
